// File: rtl/ax_pred_mode_ctrl.sv
// ax_pred_mode_ctrl: train/active/cooldown sequencer that decides when the
// BranchDecider should trust AXBTB hits instead of the normal predictor.
// A loop-begin buffer hit starts a training window. A quiet window promotes
// to ACTIVE, a noisy one backs off through COOLDOWN. ACTIVE is held while
// hits keep arriving and mispredictions stay under threshold.

// Per-lane qualifier: a lane takes the AXBTB decision only when approximate
// mode is on, the lane is fetching, and the AXBTB actually hit.
module ax_pred_lane_sel (
    input  logic en_i,
    input  logic fetch_vld_i,
    input  logic axbtb_hit_i,
    output logic sel_o
);
    assign sel_o = en_i & fetch_vld_i & axbtb_hit_i;
endmodule

module ax_pred_mode_ctrl #(
    parameter int FETCH_WIDTH    = 2,
    parameter int RESOLVE_WIDTH  = 2,
    parameter int CNT_WIDTH      = 10,
    parameter int TRAIN_CYCLES   = 64,
    parameter int MISPRED_THRESH = 3,
    parameter int ACTIVE_TIMEOUT = 256,
    parameter int COOL_CYCLES    = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [FETCH_WIDTH-1:0]   fetchValid,
    input  logic [FETCH_WIDTH-1:0]   bufferHit,
    input  logic [FETCH_WIDTH-1:0]   axbtbHit,
    input  logic [RESOLVE_WIDTH-1:0] resolveValid,
    input  logic [RESOLVE_WIDTH-1:0] resolveMispred,
    output logic                     axEnable,
    output logic [FETCH_WIDTH-1:0]   axSel,
    output logic [1:0]               state,
    output logic [7:0]               mispredCount,
    output logic [31:0]              activeCycles
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_TRAIN    = 2'd1;
    localparam logic [1:0] S_ACTIVE   = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;

    // Terminal counts. Each phase exits on its last count, so counters
    // never need to hold the full parameter value and cannot wrap.
    localparam logic [CNT_WIDTH-1:0] TRAIN_LAST   = CNT_WIDTH'(TRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(ACTIVE_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] COOL_LAST    = CNT_WIDTH'(COOL_CYCLES - 1);
    localparam logic [8:0]           THRESH       = 9'(MISPRED_THRESH);
    localparam longint               CNT_SPAN     = longint'(1) << CNT_WIDTH;

    if (CNT_WIDTH < 1 || CNT_WIDTH > 30 ||
        TRAIN_CYCLES < 1 || longint'(TRAIN_CYCLES) > CNT_SPAN ||
        ACTIVE_TIMEOUT < 1 || longint'(ACTIVE_TIMEOUT) > CNT_SPAN ||
        COOL_CYCLES < 1 || longint'(COOL_CYCLES) > CNT_SPAN ||
        MISPRED_THRESH < 0 || MISPRED_THRESH > 255 ||
        RESOLVE_WIDTH < 1 || RESOLVE_WIDTH > 255 || FETCH_WIDTH < 1) begin : g_bad_param
        $error("ax_pred_mode_ctrl: parameter out of range for CNT_WIDTH");
    end

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] phase_q, phase_d;
    logic [CNT_WIDTH-1:0] idle_q,  idle_d;
    logic [7:0]           mcnt_q,  mcnt_d;
    logic [31:0]          act_q,   act_d;

    logic       hit;
    logic [7:0] mp;
    logic [8:0] mc_sum;
    logic [7:0] mc_sat;
    logic [31:0] act_inc;

    assign hit     = |(fetchValid & bufferHit);
    assign mc_sum  = {1'b0, mcnt_q} + {1'b0, mp};
    assign mc_sat  = mc_sum[8] ? 8'hFF : mc_sum[7:0];
    assign act_inc = (&act_q) ? act_q : act_q + 32'd1;

    // Count mispredictions reported this cycle across all resolve slots.
    always_comb begin
        mp = '0;
        for (int j = 0; j < RESOLVE_WIDTH; j++) begin
            mp = mp + 8'(resolveValid[j] & resolveMispred[j]);
        end
    end

    // Phase sequencing. Every exit from a counting phase clears phase, idle
    // and window counters so the next phase starts from a clean slate.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idle_d  = idle_q;
        mcnt_d  = mcnt_q;
        act_d   = act_q;
        if (flush) begin
            state_d = S_IDLE;
            phase_d = '0;
            idle_d  = '0;
            mcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        state_d = S_TRAIN;
                        phase_d = '0;
                        mcnt_d  = '0;
                    end
                end
                S_TRAIN: begin
                    phase_d = phase_q + CNT_WIDTH'(1);
                    mcnt_d  = mc_sat;
                    if (phase_q == TRAIN_LAST) begin
                        state_d = (mc_sum <= THRESH) ? S_ACTIVE : S_COOLDOWN;
                        phase_d = '0;
                        idle_d  = '0;
                        mcnt_d  = '0;
                    end
                end
                S_ACTIVE: begin
                    act_d  = act_inc;
                    idle_d = hit ? '0 : idle_q + CNT_WIDTH'(1);
                    if (phase_q == TRAIN_LAST) begin
                        phase_d = '0;
                        mcnt_d  = '0;
                    end else begin
                        phase_d = phase_q + CNT_WIDTH'(1);
                        mcnt_d  = mc_sat;
                    end
                    // Threshold exceed outranks the idle timeout.
                    if (mc_sum > THRESH) begin
                        state_d = S_COOLDOWN;
                        phase_d = '0;
                        idle_d  = '0;
                        mcnt_d  = '0;
                    end else if (!hit && idle_q == TIMEOUT_LAST) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                        idle_d  = '0;
                        mcnt_d  = '0;
                    end
                end
                default: begin
                    if (phase_q == COOL_LAST) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            idle_q  <= '0;
            mcnt_q  <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idle_q  <= idle_d;
            mcnt_q  <= mcnt_d;
            act_q   <= act_d;
        end
    end

    assign axEnable     = (state_q == S_ACTIVE);
    assign state        = state_q;
    assign mispredCount = mcnt_q;
    assign activeCycles = act_q;

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
        ax_pred_lane_sel u_sel (
            .en_i        (axEnable),
            .fetch_vld_i (fetchValid[i]),
            .axbtb_hit_i (axbtbHit[i]),
            .sel_o       (axSel[i])
        );
    end

endmodule

// File: tb/tb_ax_pred_mode_ctrl.sv
// Scoreboard bench for ax_pred_mode_ctrl: the stimulus process pushes the
// expected outputs of each cycle, a negedge monitor pops and compares.
module tb_ax_pred_mode_ctrl;

    localparam int TC = 64;
    localparam int TH = 3;
    localparam int AT = 256;
    localparam int CC = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  fetchValid = '0, bufferHit = '0, axbtbHit = '0;
    logic [1:0]  resolveValid = '0, resolveMispred = '0;
    logic        axEnable;
    logic [1:0]  axSel;
    logic [1:0]  state;
    logic [7:0]  mispredCount;
    logic [31:0] activeCycles;

    ax_pred_mode_ctrl #(
        .FETCH_WIDTH(2), .RESOLVE_WIDTH(2), .CNT_WIDTH(10),
        .TRAIN_CYCLES(TC), .MISPRED_THRESH(TH),
        .ACTIVE_TIMEOUT(AT), .COOL_CYCLES(CC)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetchValid(fetchValid), .bufferHit(bufferHit), .axbtbHit(axbtbHit),
        .resolveValid(resolveValid), .resolveMispred(resolveMispred),
        .axEnable(axEnable), .axSel(axSel), .state(state),
        .mispredCount(mispredCount), .activeCycles(activeCycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic [1:0]  sel;
        logic [7:0]  mc;
        logic [31:0] ac;
    } exp_t;

    exp_t sbq[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode name, position in phase, cycles since last hit,
    // window mispredict total, total active cycles.
    int     m_st, m_ph, m_idl, m_mc;
    longint m_ac;

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_idl = 0; m_mc = 0; m_ac = 0;
    endtask

    task automatic model_step(input bit r, input bit f, input bit h, input int mp);
        int tot;
        tot = m_mc + mp;
        if (r) begin
            model_reset();
        end else if (f) begin
            m_st = 0; m_ph = 0; m_idl = 0; m_mc = 0;
        end else if (m_st == 0) begin
            if (h) begin m_st = 1; m_ph = 0; m_mc = 0; end
        end else if (m_st == 1) begin
            if (m_ph == TC - 1) begin
                m_st = (tot <= TH) ? 2 : 3;
                m_ph = 0; m_idl = 0; m_mc = 0;
            end else begin
                m_ph++; m_mc = (tot > 255) ? 255 : tot;
            end
        end else if (m_st == 2) begin
            if (m_ac < 64'hFFFF_FFFF) m_ac++;
            if (tot > TH) begin
                m_st = 3; m_ph = 0; m_idl = 0; m_mc = 0;
            end else if (!h && m_idl == AT - 1) begin
                m_st = 0; m_ph = 0; m_idl = 0; m_mc = 0;
            end else begin
                m_idl = h ? 0 : m_idl + 1;
                if (m_ph == TC - 1) begin m_ph = 0; m_mc = 0; end
                else begin m_ph++; m_mc = (tot > 255) ? 255 : tot; end
            end
        end else begin
            if (m_ph == CC - 1) begin m_st = 0; m_ph = 0; end
            else m_ph++;
        end
    endtask

    // One clock cycle: drive inputs, record expected outputs, advance model.
    task automatic cyc(input bit r, input bit f, input logic [1:0] fv, input logic [1:0] bh,
                       input logic [1:0] ah, input logic [1:0] rv, input logic [1:0] rm);
        exp_t e;
        @(posedge clk); #1;
        rst = r; flush = f; fetchValid = fv; bufferHit = bh; axbtbHit = ah;
        resolveValid = rv; resolveMispred = rm;
        e.st  = 2'(m_st);
        e.en  = (m_st == 2);
        e.sel = (m_st == 2) ? (fv & ah) : 2'b00;
        e.mc  = 8'(m_mc);
        e.ac  = 32'(m_ac);
        sbq.push_back(e);
        model_step(r, f, |(fv & bh), $countones(rv & rm));
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++)
            cyc(0, 0, 2'($urandom), 2'b00, 2'($urandom), 2'($urandom), 2'b00);
    endtask

    task automatic hit1();
        cyc(0, 0, 2'b01, 2'b01, 2'($urandom), 2'b00, 2'b00);
    endtask

    // TRAIN window with mispredicts injected at two chosen cycles.
    task automatic train(input int k1, input logic [1:0] m1, input int k2, input logic [1:0] m2);
        for (int k = 0; k < TC; k++) begin
            if (k == k1)      cyc(0, 0, 2'($urandom), 2'b00, 2'($urandom), m1, m1);
            else if (k == k2) cyc(0, 0, 2'($urandom), 2'b00, 2'($urandom), m2, m2);
            else              quiet(1);
        end
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            vectors++;
            if (state !== e.st) begin
                miscompares++;
                $display("FAIL state @%0t: got %0d want %0d", $time, state, e.st);
            end
            if (axEnable !== e.en) begin
                miscompares++;
                $display("FAIL axEnable @%0t: got %0b want %0b", $time, axEnable, e.en);
            end
            if (axSel !== e.sel) begin
                miscompares++;
                $display("FAIL axSel @%0t: got %b want %b", $time, axSel, e.sel);
            end
            if (mispredCount !== e.mc) begin
                miscompares++;
                $display("FAIL mispredCount @%0t: got %0d want %0d", $time, mispredCount, e.mc);
            end
            if (activeCycles !== e.ac) begin
                miscompares++;
                $display("FAIL activeCycles @%0t: got %0d want %0d", $time, activeCycles, e.ac);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);

        // Reset held with busy inputs
        repeat (3) cyc(1, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11);
        quiet(2);

        // Clean train into ACTIVE, then lane select check
        hit1();
        quiet(TC);
        cyc(0, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00);

        // Four mispredicts in one window abort ACTIVE, then full cooldown
        cyc(0, 0, 2'b11, 2'b00, 2'b10, 2'b11, 2'b11);
        cyc(0, 0, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11);
        quiet(CC + 2);

        // Noisy train, total 3 -> ACTIVE
        hit1();
        train(10, 2'b11, TC - 1, 2'b01);

        // Hits every 200 cycles keep ACTIVE; silence times out
        for (int r = 0; r < 3; r++) begin
            quiet(199);
            cyc(0, 0, 2'b10, 2'b11, 2'($urandom), 2'b00, 2'b00);
        end
        quiet(AT + 4);

        // Noisy train, total 4 -> COOLDOWN
        hit1();
        train(10, 2'b11, TC - 1, 2'b11);
        quiet(CC + 2);

        // Timeout and threshold exceed on the same cycle
        hit1();
        quiet(TC);
        quiet(AT - 2);
        cyc(0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11);
        cyc(0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11);
        quiet(CC + 2);

        // Flush at TRAIN cycle 30
        hit1();
        for (int k = 0; k < 30; k++) begin
            if (k == 5) cyc(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
            else quiet(1);
        end
        cyc(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        quiet(2);

        // Flush at ACTIVE cycle 5
        hit1();
        quiet(TC);
        quiet(2);
        cyc(0, 0, 2'b11, 2'b00, 2'b11, 2'b10, 2'b10);
        quiet(2);
        cyc(0, 1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00);
        quiet(2);

        // Hit together with flush stays in IDLE
        cyc(0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        quiet(2);

        // Randomized traffic
        for (int n = 0; n < 8000; n++) begin
            logic r, f;
            logic [1:0] bh, rm;
            r  = ($urandom_range(0, 2999) == 0);
            f  = ($urandom_range(0, 399) == 0);
            bh = ($urandom_range(0, 119) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rm = {($urandom_range(0, 49) == 0), ($urandom_range(0, 49) == 0)};
            cyc(r, f, 2'($urandom), bh, 2'($urandom), 2'($urandom), rm);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 8 && sbq.size() != 0; k++) @(posedge clk);
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
